// File: rtl/serial_pkg.sv
// Shared constants and helpers for the MSB-first serial link (transmitter and receiver).
// Latency: none, declarations only.
// Backpressure: not applicable.
package serial_pkg;

    // Default word width used by both ends of the link.
    localparam int SERIAL_DATA_WIDTH = 4;

    // Bit-counter width for a given word width; at least one bit even for 1-bit words.
    function automatic int cnt_w(input int data_width);
        if (data_width <= 1) begin
            return 1;
        end
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// Bundles the serial input, parallel output handshake and status signals of the receiver.
// Latency: none, wiring only.
// Backpressure: p_valid/p_ready on the parallel side; the serial side cannot be stalled.
interface sipo_rx_if #(
    parameter int DATA_WIDTH = serial_pkg::SERIAL_DATA_WIDTH
);
    logic                  s_in;
    logic                  s_en;
    logic                  sync;
    logic [DATA_WIDTH-1:0] p_out;
    logic                  p_valid;
    logic                  p_ready;
    logic                  overrun;
    logic                  ovr_clr;
    logic                  busy;

    // Receiver side: consumes serial bits and the consumer's ready, drives the word port.
    modport master (
        input  s_in,
        input  s_en,
        input  sync,
        input  p_ready,
        input  ovr_clr,
        output p_out,
        output p_valid,
        output overrun,
        output busy
    );

    // Environment side: drives serial bits and consumes the word port.
    modport slave (
        output s_in,
        output s_en,
        output sync,
        output p_ready,
        output ovr_clr,
        input  p_out,
        input  p_valid,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/sipo_shifter.sv
// Shift register plus bit counter; flags the enabled cycle that completes a word.
// Latency: o_word/o_word_done are combinational on the completing bit's cycle.
// Backpressure: none; a bit is taken on every i_s_en cycle.
module sipo_shifter
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = SERIAL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_s_in,
    input  logic                  i_s_en,
    input  logic                  i_sync,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_word_done,
    output logic                  o_busy
);

    localparam int CW = cnt_w(DATA_WIDTH);

    generate
        if (DATA_WIDTH == 1) begin : g_w1
            // Every enabled bit is a whole word; nothing to accumulate.
            assign o_word      = i_s_in;
            assign o_word_done = i_s_en;
            assign o_busy      = 1'b0;
        end else begin : g_wn
            localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

            // Only the DATA_WIDTH-1 most recent bits are kept: the word is formed
            // from them plus the live input bit on the completing cycle, so the
            // oldest bit of a full-width register would never be read.
            logic [DATA_WIDTH-2:0] r_shreg;
            logic [CW-1:0]         r_cnt;
            logic [DATA_WIDTH-2:0] w_shreg_base;
            logic [CW-1:0]         w_cnt_base;
            logic [DATA_WIDTH-1:0] w_next;
            logic                  w_done;

            // sync discards the partial word so a coincident bit starts a fresh one.
            always_comb begin
                w_shreg_base = r_shreg;
                w_cnt_base   = r_cnt;
                if (i_sync) begin
                    w_shreg_base = '0;
                    w_cnt_base   = '0;
                end
                w_next = {w_shreg_base, i_s_in};
                w_done = i_s_en && (w_cnt_base == LAST);
            end

            // Shift in one bit per enabled cycle; counter wraps on word completion.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shreg <= '0;
                    r_cnt   <= '0;
                end else if (i_s_en) begin
                    r_shreg <= w_next[DATA_WIDTH-2:0];
                    r_cnt   <= w_done ? '0 : w_cnt_base + 1'b1;
                end else if (i_sync) begin
                    r_shreg <= '0;
                    r_cnt   <= '0;
                end
            end

            assign o_word      = w_next;
            assign o_word_done = w_done;
            assign o_busy      = (r_cnt != '0);
        end
    endgenerate

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver with one holding register and a sticky overrun flag.
// Latency: word visible on p_out/p_valid the cycle after its last bit is sampled.
// Backpressure: p_valid/p_ready; a word completing while held and not consumed is dropped.
module sipo_rx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = SERIAL_DATA_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    sipo_rx_if.master bus
);

    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_done;
    logic                  w_busy;
    logic                  w_xfer;
    logic                  w_out_free;

    logic [DATA_WIDTH-1:0] r_p_out;
    logic                  r_p_valid;
    logic                  r_overrun;

    sipo_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .i_s_in      (bus.s_in),
        .i_s_en      (bus.s_en),
        .i_sync      (bus.sync),
        .o_word      (w_word),
        .o_word_done (w_word_done),
        .o_busy      (w_busy)
    );

    // The holding register is free when empty or being emptied this cycle.
    assign w_xfer     = r_p_valid && bus.p_ready;
    assign w_out_free = !r_p_valid || bus.p_ready;

    // Holding register: load on completion when free, otherwise drain on transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_out   <= '0;
            r_p_valid <= 1'b0;
        end else if (w_word_done && w_out_free) begin
            r_p_out   <= w_word;
            r_p_valid <= 1'b1;
        end else if (w_xfer) begin
            r_p_valid <= 1'b0;
        end
    end

    // Sticky overrun: a new drop takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_word_done && !w_out_free) begin
            r_overrun <= 1'b1;
        end else if (bus.ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus.p_out   = r_p_out;
    assign bus.p_valid = r_p_valid;
    assign bus.overrun = r_overrun;
    assign bus.busy    = w_busy;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: vector table plus hand sequences for multi-cycle corners.
// Latency: checks sampled 1 time unit after the rising edge; transfers sampled on the falling edge.
// Backpressure: exercised with p_ready held high, held low, and raised on a completion cycle.
module tb_sipo_rx;
    import serial_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sipo_rx_if #(.DATA_WIDTH(W)) bus ();

    sipo_rx #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] bits;
        int           gap_pos;
        int           gap_len;
        logic [W-1:0] exp_out;
        logic         exp_ovr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus.p_valid && bus.p_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_xfer actual=%0h expected=none", bus.p_out);
            end else begin
                check("xfer_word", {28'd0, bus.p_out}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_bit(input logic b, input logic en, input logic sy);
        bus.s_in = b;
        bus.s_en = en;
        bus.sync = sy;
        @(posedge clk);
        #1;
        bus.s_en = 1'b0;
        bus.sync = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i], 1'b1, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.s_in    = 1'b0;
        bus.s_en    = 1'b0;
        bus.sync    = 1'b0;
        bus.p_ready = 1'b0;
        bus.ovr_clr = 1'b0;
        idle(2);
        check("rst_p_out",   {28'd0, bus.p_out}, 32'd0);
        check("rst_p_valid", {31'd0, bus.p_valid}, 32'd0);
        check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        check("rst_busy",    {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        idle(1);

        // Basic receive: busy after bits 1..3, clear after bit 4; word visible next cycle.
        bus.p_ready = 1'b1;
        exp_q.push_back(4'b1011);
        begin
            logic [W-1:0] w;
            w = 4'b1011;
            for (int i = 0; i < W; i++) begin
                send_bit(w[W-1-i], 1'b1, 1'b0);
                check("basic_busy", {31'd0, bus.busy}, (i < W - 1) ? 32'd1 : 32'd0);
            end
        end
        check("basic_p_valid", {31'd0, bus.p_valid}, 32'd1);
        check("basic_p_out",   {28'd0, bus.p_out}, {28'd0, 4'b1011});
        idle(2);

        // Table: back-to-back words with consumer ready, some with mid-word gaps.
        vecs[0] = '{bits: 4'b1011, gap_pos: -1, gap_len: 0, exp_out: 4'b1011, exp_ovr: 1'b0};
        vecs[1] = '{bits: 4'b0101, gap_pos: -1, gap_len: 0, exp_out: 4'b0101, exp_ovr: 1'b0};
        vecs[2] = '{bits: 4'b0110, gap_pos: 1,  gap_len: 3, exp_out: 4'b0110, exp_ovr: 1'b0};
        vecs[3] = '{bits: 4'b1111, gap_pos: 0,  gap_len: 2, exp_out: 4'b1111, exp_ovr: 1'b0};
        vecs[4] = '{bits: 4'b1000, gap_pos: 2,  gap_len: 1, exp_out: 4'b1000, exp_ovr: 1'b0};
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(vecs[v].exp_out);
            for (int i = 0; i < W; i++) begin
                send_bit(vecs[v].bits[W-1-i], 1'b1, 1'b0);
                if (i == vecs[v].gap_pos) begin
                    idle(vecs[v].gap_len);
                    check("gap_busy_held", {31'd0, bus.busy}, 32'd1);
                end
            end
            check("vec_p_out",   {28'd0, bus.p_out}, {28'd0, vecs[v].exp_out});
            check("vec_p_valid", {31'd0, bus.p_valid}, 32'd1);
            check("vec_overrun", {31'd0, bus.overrun}, {31'd0, vecs[v].exp_ovr});
        end
        idle(2);
        check("table_drained", exp_q.size(), 32'd0);

        // Overrun: consumer stalled, second word dropped.
        bus.p_ready = 1'b0;
        exp_q.push_back(4'b1011);
        send_word(4'b1011);
        check("ovr_first_valid", {31'd0, bus.p_valid}, 32'd1);
        check("ovr_first_flag",  {31'd0, bus.overrun}, 32'd0);
        send_word(4'b0101);
        check("ovr_p_out_kept", {28'd0, bus.p_out}, {28'd0, 4'b1011});
        check("ovr_flag_set",   {31'd0, bus.overrun}, 32'd1);
        // Clear coinciding with another drop: the set must win.
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("ovr_held_before_clr", {31'd0, bus.overrun}, 32'd1);
        bus.ovr_clr = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0);
        check("ovr_set_wins", {31'd0, bus.overrun}, 32'd1);
        check("ovr_p_out_still", {28'd0, bus.p_out}, {28'd0, 4'b1011});
        idle(1);
        bus.ovr_clr = 1'b0;
        check("ovr_cleared", {31'd0, bus.overrun}, 32'd0);
        bus.p_ready = 1'b1;
        idle(1);
        bus.p_ready = 1'b0;
        check("ovr_drained_valid", {31'd0, bus.p_valid}, 32'd0);

        // Completion and consume on the same cycle: new word loads, no overrun.
        exp_q.push_back(4'b1100);
        send_word(4'b1100);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        exp_q.push_back(4'b0011);
        bus.p_ready = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0);
        check("same_cyc_p_valid", {31'd0, bus.p_valid}, 32'd1);
        check("same_cyc_p_out",   {28'd0, bus.p_out}, {28'd0, 4'b0011});
        check("same_cyc_overrun", {31'd0, bus.overrun}, 32'd0);
        idle(2);

        // Resync: partial 1,1 discarded; sync+bit starts the new word.
        exp_q.push_back(4'b0011);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b1);
        check("sync_busy", {31'd0, bus.busy}, 32'd1);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("sync_p_out", {28'd0, bus.p_out}, {28'd0, 4'b0011});
        idle(2);

        // Reset mid-word: partial bits must not leak into the next word.
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        exp_q.push_back(4'b1111);
        send_word(4'b1111);
        check("rst_mid_p_out", {28'd0, bus.p_out}, {28'd0, 4'b1111});
        idle(2);

        // Reset while a word is held drops it.
        bus.p_ready = 1'b0;
        send_word(4'b1010);
        check("held_before_rst", {31'd0, bus.p_valid}, 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("held_rst_valid", {31'd0, bus.p_valid}, 32'd0);
        check("held_rst_p_out", {28'd0, bus.p_out}, 32'd0);

        idle(2);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver: the receive end of the team's MSB-first serial link, paired with the existing parallel-in/serial-out transmitter. It samples one bit per enabled clock, assembles `DATA_WIDTH`-bit words, and presents each completed word on a valid/ready output port. A single holding register lets reception continue while the consumer stalls. Lost words are reported through a sticky overrun flag.

## Interface
- `DATA_WIDTH`, default 4: word width in bits, must be ≥ 1.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `s_in`, input, 1: serial data, MSB first.
- `s_en`, input, 1: `s_in` holds a valid bit this cycle.
- `sync`, input, 1: word-boundary marker; restarts bit alignment.
- `p_out`, output, `DATA_WIDTH`: last completed word.
- `p_valid`, output, 1: `p_out` holds an unconsumed word.
- `p_ready`, input, 1: consumer accepts `p_out` this cycle.
- `overrun`, output, 1: sticky; a completed word was dropped.
- `ovr_clr`, input, 1: clears `overrun`.
- `busy`, output, 1: partial word in progress (bit count ≠ 0).

## Operation
- Internal state:
  - `shreg[DATA_WIDTH-1:0]`.
  - `cnt`, with `max(1,$clog2(DATA_WIDTH))` bits.
  - Output register `p_out`/`p_valid`.
- Bit capture, when `s_en`=1: `shreg <= {shreg[DATA_WIDTH-2:0], s_in}` and `cnt++`. The first bit received ends up in `p_out[DATA_WIDTH-1]`.
- Word completion: the `s_en` cycle with `cnt == DATA_WIDTH-1`.
  - Assembled word is `{shreg[DATA_WIDTH-2:0], s_in}`.
  - `cnt` wraps to 0.
- Output handshake:
  - Transfer occurs when `p_valid && p_ready`.
  - `p_valid` clears after a transfer unless a new word completes in the same cycle.
- Word completes while the output register is free (`!p_valid`, or `p_ready` this cycle):
  - `p_out` loads the word and `p_valid` = 1.
  - Completion plus consume in the same cycle: new word loads, `p_valid` stays 1, no overrun.
- Word completes while `p_valid && !p_ready`:
  - New word is dropped and `p_out` is unchanged.
  - `overrun` is set.
- `sync`=1:
  - Any partial word is discarded and `cnt` is forced to 0.
  - If `s_en` is also 1, that bit is taken as bit 0 of a new word (`cnt` becomes 1, or the word completes immediately when `DATA_WIDTH`=1).
  - `sync` never affects `p_out`/`p_valid`.
- `ovr_clr` and a new overrun in the same cycle: `overrun` stays 1 (set wins).
- `DATA_WIDTH`=1: every `s_en` cycle completes a word. `cnt` stays 0 and `busy` stays 0.
- `p_ready` while `!p_valid`: no effect.

## Timing
- Reset values: `p_out`=0, `p_valid`=0, `overrun`=0, `busy`=0, `shreg`=0, `cnt`=0.
- Reset mid-word discards the partial word. Reset while `p_valid` drops the held word.
- Latency: `p_out`/`p_valid` update on the edge that samples the last bit and are visible the following cycle.
- Maximum throughput: one bit per clock, so one word every `DATA_WIDTH` cycles.
- A consumer holding `p_ready`=1 never causes overrun.
- All outputs are registered. No combinational path from inputs to outputs.
- Gaps (`s_en`=0) of any length are allowed mid-word; state holds.

## Structure
- Package `serial_pkg`:
  - `DATA_WIDTH` default constant.
  - Count-width function `cnt_w(DATA_WIDTH)`.
  - Shared with the transmitter so both ends agree on width and bit order.
- Natural sub-module `sipo_shifter`: shift register plus bit counter, producing `word` and `word_done`.
- Top level holds the output register, handshake and overrun logic.

## Test plan
- **Basic receive.** `rst`, then `s_en`=1 with `s_in` = 1,0,1,1 on consecutive cycles. Required: `p_out`=4'b1011 and `p_valid`=1 the cycle after the 4th bit; `busy` high for cycles 2–4.
- **Gapped input.** Bits 0,1,1,0 with `s_en` deasserted for 3 cycles between bits 2 and 3. Required: `p_out`=4'b0110; state held during the gaps.
- **Back-to-back with consumer ready.** `p_ready`=1, 1011 followed immediately by 0101. Required: two transfers, `p_out`=1011 then 0101, `overrun`=0.
- **Overrun and clear.** `p_ready`=0, send 1011 then 0101. Required: `p_out` stays 1011 and `overrun`=1. Then `ovr_clr` → `overrun`=0; `p_ready` → `p_valid`=0.
- **Resync.** Send 1,1 (partial), then `sync`+`s_en` with `s_in`=0, then bits 0,1,1. Required: `p_out`=4'b0011.
- **Reset mid-word.** Send 1,0 (partial), assert `rst`, then send 1,1,1,1. Required: `p_out`=4'b1111, not 4'b1011 (no stale bits).
